// File: rtl/sigma_delta_pkg.sv
// Shared constants for the sigma-delta DAC: dither LFSR definition and channel slice helper.
// No logic, no latency; no flow control.
package sigma_delta_pkg;

    localparam int LFSR_W = 16;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    function automatic int sample_lsb(input int ch, input int bits);
        return ch * bits;
    endfunction

endpackage

// File: rtl/sdm_channel.sv
// First-order sigma-delta modulator: one accumulator whose carry is the registered pin.
// One clock from accumulate to pin; free-running, no backpressure.
module sdm_channel
    import sigma_delta_pkg::*;
#(
    parameter int DAC_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DAC_BITS-1:0] sample,
    input  logic                cin,
    output logic                pin
);

    logic [DAC_BITS-1:0] acc;
    logic [DAC_BITS:0]   sum;

    // The carry out of the accumulator wrap is the output bit
    assign sum = {1'b0, acc} + {1'b0, sample} + {{DAC_BITS{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            pin <= 1'b0;
        end else begin
            acc <= sum[DAC_BITS-1:0];
            pin <= sum[DAC_BITS];
        end
    end

endmodule

// File: rtl/sigma_delta_dac.sv
// Multi-channel sigma-delta DAC; samples load into the modulators every RATE_DIV clocks.
// One-deep holding register: data_ready drops the cycle after accept until the next strobe; SIGMA_DELTA_DAC_DITHER_EN adds LFSR dither.
module sigma_delta_dac
    import sigma_delta_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DAC_BITS = 16,
    parameter int RATE_DIV = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DAC_BITS-1:0] data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [CHANNELS-1:0]          pins_out,
    output logic                         sample_strobe,
    output logic                         underrun
);

    localparam int SW    = CHANNELS * DAC_BITS;
    localparam int DIV_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(RATE_DIV - 2);

    logic [DIV_W-1:0]    div;
    logic                full;
    logic [SW-1:0]       hold;
    logic [SW-1:0]       active;
    logic [CHANNELS-1:0] cin;
    logic                accept;

    assign data_ready = !full;
    assign accept     = data_valid && !full;

    // Strobe is registered one count early so it is high while div == RATE_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div           <= '0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
            full          <= 1'b0;
            hold          <= '0;
            active        <= '0;
        end else begin
            div           <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            sample_strobe <= (div == DIV_PRE);
            underrun      <= sample_strobe && !full;
            if (sample_strobe && full) begin
                active <= hold;
            end
            if (accept) begin
                hold <= data_in;
            end
            // accept implies full was clear, so it never collides with a strobe drain
            if (accept) begin
                full <= 1'b1;
            end else if (sample_strobe) begin
                full <= 1'b0;
            end
        end
    end

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cin
        assign cin[i] = lfsr[i % LFSR_W];
    end
`else
    assign cin = '0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sdm_channel #(
            .DAC_BITS(DAC_BITS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .sample(active[sample_lsb(i, DAC_BITS) +: DAC_BITS]),
            .cin   (cin[i]),
            .pin   (pins_out[i])
        );
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac with CHANNELS=2, DAC_BITS=4, RATE_DIV=16.
module tb_sigma_delta_dac;

    localparam int CH = 2;
    localparam int DB = 4;
    localparam int RD = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*DB-1:0] data_in;
    logic            data_valid;
    logic            data_ready;
    logic [CH-1:0]   pins_out;
    logic            sample_strobe;
    logic            underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ones0  = 0;
    int ones1  = 0;
    int k      = 0;

    always #5 clk = ~clk;

    sigma_delta_dac #(
        .CHANNELS(CH),
        .DAC_BITS(DB),
        .RATE_DIV(RD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .pins_out     (pins_out),
        .sample_strobe(sample_strobe),
        .underrun     (underrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic string tag(input string s);
        return $sformatf("%s@%0d", s, cyc);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Exact pin patterns only exist without dither
    task automatic check_pins(input string name, input logic [1:0] exp);
`ifndef SIGMA_DELTA_DAC_DITHER_EN
        check(name, 32'(pins_out), 32'(exp));
`endif
    endtask

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        #1;
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_pins", 32'(pins_out), 32'd0);
        check("rst_strobe", 32'(sample_strobe), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        data_in    = {4'd3, 4'd9};
        data_valid = 1'b1;
        repeat (3) step();
        check("rst_ignores_hs", 32'(data_ready), 32'd1);

        // Release; cycle 0 is the interval before the first edge
        data_valid = 1'b0;
        rst        = 1'b0;
        cyc        = 0;
        data_in    = {4'd0, 4'd4};
        data_valid = 1'b1;
        step();
        check("accept_ready_low", 32'(data_ready), 32'd0);
        data_valid = 1'b0;

        // S=4 on ch0 from edge 16; empty strobes at 32 and 48, sample lands in hold on 47
        while (cyc < 64) begin
            step();
            check(tag("strobe"), 32'(sample_strobe), 32'(cyc % 16 == 15));
            check(tag("underrun"), 32'(underrun), 32'(cyc == 32 || cyc == 48));
            check(tag("ready"), 32'(data_ready), 32'((cyc >= 16 && cyc <= 47) || cyc == 64));
            check_pins(tag("pins_s4"), {1'b0, (cyc > 16 && cyc % 4 == 0)});
            if (cyc == 47) begin
                data_in    = {4'd1, 4'd15};
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end

        // S=15 on ch0 and S=1 on ch1 from edge 64, valid held continuously
        data_valid = 1'b1;
        while (cyc < 111) begin
            step();
            k = cyc - 64;
            check(tag("strobe"), 32'(sample_strobe), 32'(cyc % 16 == 15));
            check(tag("underrun_none"), 32'(underrun), 32'd0);
            check(tag("ready_toggle"), 32'(data_ready), 32'(cyc % 16 == 0));
            check_pins(tag("pins_s15"), {(k % 16 == 0), (k % 16 != 1)});
        end

        // Mid-stream reset while full and strobing
        check("pre_rst_full", 32'(data_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_pins", 32'(pins_out), 32'd0);
        check("mid_rst_ready", 32'(data_ready), 32'd1);
        check("mid_rst_strobe", 32'(sample_strobe), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        step();
        check("mid_rst_hold_ready", 32'(data_ready), 32'd1);
        check("mid_rst_hold_pins", 32'(pins_out), 32'd0);

        data_valid = 1'b0;
        rst        = 1'b0;
        cyc        = 0;
        while (cyc < 20) begin
            step();
            check(tag("post_rst_strobe"), 32'(sample_strobe), 32'(cyc == 15));
            check(tag("post_rst_underrun"), 32'(underrun), 32'(cyc == 16));
            check(tag("post_rst_ready"), 32'(data_ready), 32'd1);
            check_pins(tag("post_rst_pins"), 2'b00);
        end

        // S=8 on ch0, loaded at edge 32, then long-run density
        data_in    = {4'd0, 4'd8};
        data_valid = 1'b1;
        step();
        check("s8_accept", 32'(data_ready), 32'd0);
        data_valid = 1'b0;
        while (cyc < 32) step();
        check("s8_load_no_underrun", 32'(underrun), 32'd0);
        repeat (4096) begin
            step();
            ones0 += int'(pins_out[0]);
            ones1 += int'(pins_out[1]);
        end
`ifdef SIGMA_DELTA_DAC_DITHER_EN
        check("dither_density", 32'(ones0 >= 2133 && ones0 <= 2219), 32'd1);
`else
        check("s8_ones_ch0", 32'(ones0), 32'd2048);
        check("s0_ones_ch1", 32'(ones1), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
